// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- UART transmitter with a valid/ready word input.
//
// Serialises one DATA_BITS word per handshake into an asynchronous frame:
// start bit (0), data bits LSB first, optional parity bit, then STOP_BITS
// stop bits (1). Bit timing comes from an internal divider that runs on the
// system clock, so no separate baud clock is needed.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit follows the data bits (odd when PARITY_ODD=1,
//                even otherwise)
//   undefined -> no parity state, no parity logic, PARITY_ODD is ignored
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit period (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    1 = odd parity, 0 = even parity
//
// Ports:
//   clk_50M   in   system clock
//   rst_n     in   synchronous active-low reset
//   tx_data   in   word to send, sampled only on the handshake edge
//   tx_valid  in   upstream has a word
//   tx_ready  out  block can accept a word (idle only)
//   tx        out  serial line, idles high
//   tx_busy   out  a frame is in progress
//   tx_done   out  one-clock pulse in the last clock of the last stop bit
//
// Every output is a flop. The line and status outputs are computed from the
// current state and take effect one clock later, so a handshake at edge N
// shows the start bit from edge N+1 onwards and the whole frame sits in
// clocks N+1 .. N+F.

module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 32'sd1);

  localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(32'sd1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 32'sd1);
  localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(32'sd1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 32'sd1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 32'sd1);

  // Elaboration-time guard against parameter values the datapath cannot hold.
  if ((CLKS_PER_BIT < 32'sd2) || (DATA_BITS < 32'sd5) || (DATA_BITS > 32'sd9) ||
      ((STOP_BITS != 32'sd1) && (STOP_BITS != 32'sd2)) ||
      ((PARITY_ODD != 32'sd0) && (PARITY_ODD != 32'sd1))) begin : g_param_check
    $error("uart_tx_frame: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [DIV_W-1:0]     div_r, div_s;
  logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 tx_r, tx_s;
  logic                 tx_ready_r, tx_ready_s;
  logic                 tx_busy_r, tx_busy_s;
  logic                 tx_done_r, tx_done_s;
  logic                 accept_s;
  logic                 bit_end_s;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_SENSE = (PARITY_ODD == 32'sd1) ? 1'b1 : 1'b0;

  logic                 parity_r, parity_s;

  // Parity of the word as it will appear on the line (even, or odd when inverted).
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] word);
    return (^word) ^ PARITY_SENSE;
  endfunction
`endif

  // State register plus all datapath and output flops.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      div_r      <= DIV_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b1;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_r      <= div_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_s;
`endif
      tx_r       <= tx_s;
      tx_ready_r <= tx_ready_s;
      tx_busy_r  <= tx_busy_s;
      tx_done_r  <= tx_done_s;
    end
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    // Gating on tx_ready_r keeps the clock after a frame idle, which
    // guarantees one idle-high clock between back-to-back frames.
    accept_s   = (state_r == S_IDLE) && tx_ready_r && tx_valid;
    bit_end_s  = (div_r == DIV_LAST);
    state_s    = state_r;
    div_s      = bit_end_s ? DIV_ZERO : (div_r + DIV_ONE);
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
`ifdef UART_TX_PARITY_EN
    parity_s   = parity_r;
`endif
    tx_s       = 1'b1;
    tx_done_s  = 1'b0;
    tx_busy_s  = (state_r != S_IDLE);
    // Ready clears on the accepting edge itself so that a tx_valid held
    // high is never seen as a second handshake during the frame.
    tx_ready_s = (state_r == S_IDLE) && !accept_s;

    case (state_r)
      S_IDLE: begin
        tx_s  = 1'b1;
        div_s = DIV_ZERO;
        if (accept_s) begin
          state_s   = S_START;
          shift_s   = tx_data;
          bit_cnt_s = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
          parity_s  = frame_parity(tx_data);
`endif
        end else begin
          state_s   = S_IDLE;
        end
      end

      S_START: begin
        tx_s = 1'b0;
        if (bit_end_s) begin
          state_s = S_DATA;
        end else begin
          state_s = S_START;
        end
      end

      S_DATA: begin
        tx_s = shift_r[0];
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_s = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
            state_s   = S_PARITY;
`else
            state_s   = S_STOP;
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
          end
        end else begin
          shift_s = shift_r;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_s = parity_r;
        if (bit_end_s) begin
          state_s   = S_STOP;
          bit_cnt_s = BIT_ZERO;
        end else begin
          state_s   = S_PARITY;
        end
      end
`endif

      // The bit counter is reused here to count stop bits.
      S_STOP: begin
        tx_s = 1'b1;
        if (bit_end_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            state_s   = S_IDLE;
            bit_cnt_s = BIT_ZERO;
            tx_done_s = 1'b1;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
          end
        end else begin
          state_s = S_STOP;
        end
      end

      default: begin
        state_s   = S_IDLE;
        div_s     = DIV_ZERO;
        bit_cnt_s = BIT_ZERO;
        tx_s      = 1'b1;
      end
    endcase
  end

  assign tx       = tx_r;
  assign tx_ready = tx_ready_r;
  assign tx_busy  = tx_busy_r;
  assign tx_done  = tx_done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame.
// Two instances share one clock: an 8-data/1-stop unit and a 7-data/2-stop
// unit (the latter with odd parity selected, which matters only when
// UART_TX_PARITY_EN is defined). The driver pushes each accepted word and its
// handshake edge into a queue; an independent monitor per instance detects
// each start bit, pops the queue and checks every clock of the frame and the
// idle clock that follows it.

module tb_uart_tx_frame;

  localparam int CPB = 4;

  typedef struct {
    logic [8:0] word;
    int         hs;
  } exp_t;

  logic       clk;
  int         cyc = 0;

  logic       rst0_n, valid0, ready0, tx0, busy0, done0;
  logic [7:0] data0;
  logic       rst7_n, valid7, ready7, tx7, busy7, done7;
  logic [6:0] data7;

  exp_t q0[$];
  exp_t q7[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en0  = 1'b0;
  bit   mon_en7  = 1'b1;
  bit   in_frame0 = 1'b0;
  bit   in_frame7 = 1'b0;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk_50M(clk), .rst_n(rst0_n), .tx_data(data0), .tx_valid(valid0),
    .tx_ready(ready0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_dut7 (
    .clk_50M(clk), .rst_n(rst7_n), .tx_data(data7), .tx_valid(valid7),
    .tx_ready(ready7), .tx(tx7), .tx_busy(busy7), .tx_done(done7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock index: at the falling edge of clock k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference line level of bit b of a frame carrying word w.
  function automatic logic exp_level(input logic [8:0] w, input int db, input int odd, input int b);
    int  p;
    logic par;
    p = 0;
`ifdef UART_TX_PARITY_EN
    p = 1;
`endif
    par = (odd == 1) ? 1'b1 : 1'b0;
    for (int i = 0; i < db; i++) par = par ^ w[i];
    if (b == 0) return 1'b0;
    else if (b <= db) return w[b-1];
    else if ((p == 1) && (b == db + 1)) return par;
    else return 1'b1;
  endfunction

  // Snapshot {tx, tx_done, tx_busy, tx_ready} of one instance.
  task automatic sample(input int which, output logic [3:0] v);
    if (which == 0) v = {tx0, done0, busy0, ready0};
    else            v = {tx7, done7, busy7, ready7};
  endtask

  task automatic monitor(input int which, input int db, input int sb, input int odd);
    exp_t       e;
    int         nb;
    int         p;
    int         c0;
    bit         en;
    bit         have;
    logic [3:0] v;
    logic [3:0] ev;
    p = 0;
`ifdef UART_TX_PARITY_EN
    p = 1;
`endif
    nb = 1 + db + p + sb;
    forever begin
      @(negedge clk);
      en = (which == 0) ? mon_en0 : mon_en7;
      sample(which, v);
      if (en && (v[3] === 1'b0)) begin
        c0 = cyc;
        have = 1'b0;
        if (which == 0) begin
          if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          in_frame0 = 1'b1;
        end else begin
          if (q7.size() > 0) begin e = q7.pop_front(); have = 1'b1; end
          in_frame7 = 1'b1;
        end
        check($sformatf("dut%0d start_has_word", which), {31'd0, have}, 32'd1);
        if (!have) begin
          e.word = 9'h000;
          e.hs   = c0 - 1;
        end
        check($sformatf("dut%0d start_latency", which), c0, e.hs + 1);
        for (int b = 0; b < nb; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if ((b != 0) || (k != 0)) begin
              @(negedge clk);
              sample(which, v);
            end
            ev = {exp_level(e.word, db, odd, b), ((b == nb - 1) && (k == CPB - 1)), 1'b1, 1'b0};
            check($sformatf("dut%0d w%0h bit%0d clk%0d", which, e.word, b, k), {28'd0, v}, {28'd0, ev});
          end
        end
        @(negedge clk);
        sample(which, v);
        check($sformatf("dut%0d idle_after_frame", which), {28'd0, v}, 32'h9);
        if (which == 0) in_frame0 = 1'b0;
        else            in_frame7 = 1'b0;
      end
    end
  endtask

  // Offer w; after the handshake drive nxt on the data bus and drop valid unless keep.
  task automatic send(input int which, input logic [8:0] w, input bit keep, input logic [8:0] nxt);
    exp_t e;
    int   n;
    logic rdy;
    n = 0;
    @(negedge clk);
    if (which == 0) begin data0 = w[7:0]; valid0 = 1'b1; rdy = ready0; end
    else            begin data7 = w[6:0]; valid7 = 1'b1; rdy = ready7; end
    while ((rdy !== 1'b1) && (n < 500)) begin
      @(negedge clk);
      n++;
      rdy = (which == 0) ? ready0 : ready7;
    end
    check($sformatf("dut%0d handshake_in_time", which), {31'd0, (n < 500)}, 32'd1);
    e.word = w;
    e.hs   = cyc + 1;
    if (which == 0) q0.push_back(e);
    else            q7.push_back(e);
    @(negedge clk);
    if (which == 0) begin data0 = nxt[7:0]; if (!keep) valid0 = 1'b0; end
    else            begin data7 = nxt[6:0]; if (!keep) valid7 = 1'b0; end
  endtask

  initial begin
    fork
      monitor(0, 8, 1, 0);
      monitor(1, 7, 2, 1);
    join_none
  end

  initial begin
    int   glitches;
    int   w;
    logic [3:0] v;
    rst0_n = 1'b0; rst7_n = 1'b0;
    valid0 = 1'b0; valid7 = 1'b0;
    data0  = 8'h00; data7 = 7'h00;
    repeat (3) @(negedge clk);
    sample(0, v);
    check("dut0 reset_values", {28'd0, v}, 32'h9);
    sample(1, v);
    check("dut7 reset_values", {28'd0, v}, 32'h9);
    rst0_n = 1'b1; rst7_n = 1'b1;

    // Abort a frame in its data phase with a one-clock reset.
    send(0, 9'h057, 1'b0, 9'h000);
    repeat (8) @(negedge clk);
    rst0_n = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    sample(0, v);
    check("dut0 midframe_reset_outputs", {28'd0, v}, 32'h9);
    glitches = 0;
    repeat (60) begin
      @(negedge clk);
      if ((done0 !== 1'b0) || (tx0 !== 1'b1) || (busy0 !== 1'b0)) glitches++;
    end
    check("dut0 aborted_frame_quiet", glitches, 0);
    q0.delete();
    mon_en0 = 1'b1;

    // Clean frames, back-to-back frames, and input changes during a frame.
    send(0, 9'h057, 1'b0, 9'h0AA);
    send(0, 9'h065, 1'b1, 9'h020);
    send(0, 9'h020, 1'b0, 9'h000);
    send(0, 9'h03C, 1'b0, 9'h000);
    repeat (35) begin
      @(negedge clk);
      data0 = 8'($urandom);
    end
    send(0, 9'h0FF, 1'b0, 9'h000);
    send(0, 9'h000, 1'b0, 9'h000);
    send(0, 9'h061, 1'b0, 9'h000);

    // Seven data bits, two stop bits.
    send(1, 9'h02E, 1'b0, 9'h07F);
    send(1, 9'h061, 1'b1, 9'h055);
    send(1, 9'h055, 1'b0, 9'h000);

    w = 0;
    while (((q0.size() != 0) || (q7.size() != 0) || in_frame0 || in_frame7) && (w < 2000)) begin
      @(negedge clk);
      w++;
    end
    check("drain_in_time", {31'd0, (w < 2000)}, 32'd1);
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
